data_memory_ws: RTL and testbench
=================================

# data_memory_ws

Parametrised, wait-stated data memory for the ARM datapath MEM stage. It is byte-addressed, big-endian and word-oriented, and adds a configurable access latency with a `ready` handshake. It also adds a relocatable base address, out-of-range detection and optional byte access. The pipeline stalls the MEM stage until `ready` pulses.

## Interface
- `DEPTH_BYTES`, default 512: array size in bytes; power of two, ≥ 4.
- `BASE_ADDR`, default 32'd1024: CPU address mapped to array byte 0; word-aligned.
- `WAIT_CYCLES`, default 3: extra wait states per access; range 0..15.
- `clk` input 1: clock; all state changes on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `mem_read` input 1: read request.
- `mem_write` input 1: write request.
- `byte_access` input 1: byte-size access (honoured only with `DMEM_BYTE_ACCESS_EN`).
- `address` input 32: CPU byte address.
- `write_data` input 32: store data.
- `read_data` output 32: registered load data.
- `ready` output 1: one-cycle completion pulse.
- `addr_err` output 1: one-cycle pulse with `ready` when the access was out of range.

## Operation
- **States:** IDLE, BUSY, DONE. A 4-bit wait counter is used in BUSY.
- **IDLE, no request:** with `mem_read` or `mem_write` both low, the block stays in IDLE.
- **IDLE, request present:** at a rising edge with `mem_read` or `mem_write` high, the request is accepted.
  - `address`, `write_data`, `byte_access` and the operation are latched.
  - If both `mem_read` and `mem_write` are high, the request is treated as a write.
  - WAIT_CYCLES=0: the access is performed at that same edge, and the next state is DONE.
  - Otherwise: the next state is BUSY and the counter loads WAIT_CYCLES.
- **BUSY:** the counter decrements at each edge. At the edge where the counter equals 1, the access is performed and the next state is DONE.
- **Inputs after acceptance:** request inputs are ignored from acceptance until the block returns to IDLE.
- **DONE:** `ready`=1, plus `addr_err` if the access was out of range. The next edge returns to IDLE unconditionally.
- **Address translation:**
  - off = latched address − BASE_ADDR, computed as 32-bit unsigned.
  - Word access: off[1:0] is forced to 0.
  - In range when address ≥ BASE_ADDR and off < DEPTH_BYTES.
- **Byte order:** big-endian. Byte off holds bits [31:24], off+1 holds [23:16], off+2 holds [15:8], off+3 holds [7:0].
- **Word read:** `read_data` is loaded with the four bytes.
- **Word write:** all four bytes are written from `write_data`.
- **Out of range:**
  - The write is suppressed and the array is unchanged.
  - A read loads `read_data` with 0.
  - `addr_err` pulses.
- **`read_data` hold behaviour:** holds its value until the next completed read. A completed write does not change it.
- **Array contents:** not affected by reset. Bytes that have never been written are undefined.

## Timing
- **Reset values:** state IDLE, counter 0, `ready`=0, `addr_err`=0, `read_data`=0.
- **Latency:** a request presented in cycle N gives `ready` high in cycle N+WAIT_CYCLES+1. With the default 3, that is 4 cycles after the request.
- **Write visibility:** write data is visible to any access accepted after the DONE cycle.
- **Throughput:** one access per WAIT_CYCLES+2 cycles. The DONE cycle never accepts a new request.
- **Reset mid-operation:** asserting `rst_n` low in BUSY returns the block to IDLE immediately.
  - A pending write is dropped and the array is unchanged.
  - No `ready` pulse is produced for the aborted request.
- **Request held high:** a request held high across DONE is re-accepted in the following IDLE cycle as a new access.

## Configuration
- `DMEM_BYTE_ACCESS_EN` defined:
  - With `byte_access`=1, off is used unaligned.
  - A read returns {24'b0, byte[off]}.
  - A write stores only `write_data[7:0]` into byte[off]; the other bytes are untouched.
  - Range check: off < DEPTH_BYTES.
- `DMEM_BYTE_ACCESS_EN` undefined:
  - `byte_access` is ignored.
  - Every access is a word access, with address[1:0] ignored.

## Test plan
- **Word write/read:** defaults; write 0x11223344 to 1028, then read 1028. Required: `ready` in the 4th cycle after each request; `read_data`=0x11223344; `addr_err`=0.
- **Alignment:** read address 1031 (word access). Required: returns 0x11223344, since the low bits are masked.
- **Out of range:** read 1020 and write 0xDEADBEEF to 1536. Required: `read_data`=0 and `addr_err` pulses with `ready` each time; a read of 1024 afterwards is unchanged.
- **Reset mid-write:** write 0xAAAAAAAA to 1028, then pull `rst_n` low in the 2nd BUSY cycle. Required: outputs return to 0 immediately; a subsequent read of 1028 returns 0x11223344.
- **Zero wait states, both requests:** WAIT_CYCLES=0; hold both `mem_read` and `mem_write` high with data 0x0000CAFE at 1032. Required: treated as a write; `ready` pulses every 2nd cycle; a read of 1032 gives 0x0000CAFE.
- **Byte access (with `DMEM_BYTE_ACCESS_EN`):** byte write 0x5A to 1029, then a word read of 1028. Required: returns 0x115A3344; a byte read of 1029 returns 0x0000005A.

Source files
------------

// File: rtl/data_memory_ws.sv
// ---------------------------------------------------------------------------
// data_memory_ws
//
// Wait-stated, byte-addressed, big-endian data memory for the MEM stage.
// Each access takes WAIT_CYCLES extra cycles and finishes with a one-cycle
// `ready` pulse; out-of-range accesses are flagged with `addr_err` in the
// same cycle. The CPU address window starts at BASE_ADDR and covers
// DEPTH_BYTES bytes.
//
// Build option:
//   DMEM_BYTE_ACCESS_EN - when defined, `byte_access`=1 selects a single
//                         unaligned byte access; otherwise every access is
//                         a word access and `byte_access` is ignored.
//
// Parameters:
//   DEPTH_BYTES  array size in bytes (power of two, >= 4)
//   BASE_ADDR    CPU address of array byte 0 (word aligned)
//   WAIT_CYCLES  extra wait states per access (0..15)
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   mem_read     read request
//   mem_write    write request (wins when both requests are high)
//   byte_access  byte-size access select
//   address      CPU byte address
//   write_data   store data
//   read_data    registered load data, held until the next completed read
//   ready        one-cycle completion pulse
//   addr_err     one-cycle pulse with ready for an out-of-range access
//
// State | meaning
// ------+-----------------------------------------------------------------
// IDLE  | waiting for a request; accepts mem_read/mem_write
// BUSY  | counting down wait states; access performed when counter == 1
// DONE  | ready (and addr_err if out of range); always returns to IDLE
// ---------------------------------------------------------------------------
module data_memory_ws #(
    parameter int unsigned DEPTH_BYTES = 512,
    parameter logic [31:0] BASE_ADDR   = 32'd1024,
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        byte_access,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        addr_err
);

    localparam int unsigned AW = $clog2(DEPTH_BYTES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        wr_q, wr_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [7:0]  mem [DEPTH_BYTES];

    logic        req;
    logic        accept;
    logic        do_access;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;
    logic        acc_wr;
    logic        acc_is_byte;
    logic [31:0] off;
    logic [31:0] lane_off;
    logic        in_range;
    logic [AW-1:0] base_idx;
    logic [AW-1:0] lane_idx [4];
    logic        lane_we  [4];
    logic [7:0]  lane_dat [4];
    logic [31:0] rd_val;

`ifdef DMEM_BYTE_ACCESS_EN
    logic        byte_q, byte_d;
`else
    logic        unused_ok;
    assign unused_ok = byte_access;
`endif

    assign req    = mem_read | mem_write;
    assign accept = (state_q == ST_IDLE) && req;

    // With zero wait states the access happens on the accepting edge, so the
    // datapath must look at the live inputs rather than the latched copies.
    assign acc_addr  = accept ? address    : addr_q;
    assign acc_wdata = accept ? write_data : wdata_q;
    assign acc_wr    = accept ? mem_write  : wr_q;

`ifdef DMEM_BYTE_ACCESS_EN
    assign acc_is_byte = accept ? byte_access : byte_q;
`else
    assign acc_is_byte = 1'b0;
`endif

    always_comb begin
        do_access = 1'b0;
        if (accept && (WAIT_CYCLES == 0)) begin
            do_access = 1'b1;
        end else if ((state_q == ST_BUSY) && (cnt_q == 4'd1)) begin
            do_access = 1'b1;
        end
    end

    // Offset is 32-bit unsigned; an address below BASE_ADDR wraps to a huge
    // offset, but the explicit lower-bound compare keeps the intent clear.
    assign off      = acc_addr - BASE_ADDR;
    assign lane_off = acc_is_byte ? off : (off & ~32'd3);
    assign in_range = (acc_addr >= BASE_ADDR) && (lane_off < 32'(DEPTH_BYTES));
    assign base_idx = lane_off[AW-1:0];

    // Lane k carries big-endian byte k of the word; a byte access uses only
    // lane 0 at the unaligned index.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            lane_idx[k] = base_idx | AW'(k);
            lane_dat[k] = acc_is_byte ? acc_wdata[7:0] : acc_wdata[8*(3-k) +: 8];
            lane_we[k]  = rst_n && do_access && acc_wr && in_range
                          && (!acc_is_byte || (k == 0));
        end
    end

    always_comb begin
        rd_val = {mem[lane_idx[0]], mem[lane_idx[1]], mem[lane_idx[2]], mem[lane_idx[3]]};
        if (acc_is_byte) begin
            rd_val = {24'b0, mem[base_idx]};
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wr_d    = wr_q;
        err_d   = err_q;
        rdata_d = rdata_q;
`ifdef DMEM_BYTE_ACCESS_EN
        byte_d  = byte_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    addr_d  = address;
                    wdata_d = write_data;
                    wr_d    = mem_write;
`ifdef DMEM_BYTE_ACCESS_EN
                    byte_d  = byte_access;
`endif
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = 4'(WAIT_CYCLES);
                    end
                end
            end
            ST_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access) begin
            err_d = !in_range;
            if (!acc_wr) begin
                rdata_d = in_range ? rd_val : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
`ifdef DMEM_BYTE_ACCESS_EN
            byte_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
`ifdef DMEM_BYTE_ACCESS_EN
            byte_q  <= byte_d;
`endif
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (lane_we[k]) begin
                mem[lane_idx[k]] <= lane_dat[k];
            end
        end
    end

    assign read_data = rdata_q;
    assign ready     = (state_q == ST_DONE);
    assign addr_err  = (state_q == ST_DONE) && err_q;

endmodule

// File: tb/tb_data_memory_ws.sv
// ---------------------------------------------------------------------------
// tb_data_memory_ws
//
// Directed bench for data_memory_ws: a default instance (WAIT_CYCLES=3) and
// a zero-wait-state instance sharing clock and reset.
// ---------------------------------------------------------------------------
module tb_data_memory_ws;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        mem_read, mem_write, byte_access;
    logic [31:0] address, write_data, read_data;
    logic        ready, addr_err;

    logic        mem_read_z, mem_write_z, byte_access_z;
    logic [31:0] address_z, write_data_z, read_data_z;
    logic        ready_z, addr_err_z;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_ws u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .byte_access (byte_access),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .addr_err    (addr_err)
    );

    data_memory_ws #(.WAIT_CYCLES(0)) u_dut_z (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_read    (mem_read_z),
        .mem_write   (mem_write_z),
        .byte_access (byte_access_z),
        .address     (address_z),
        .write_data  (write_data_z),
        .read_data   (read_data_z),
        .ready       (ready_z),
        .addr_err    (addr_err_z)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_req();
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        byte_access = 1'b0;
        address     = 32'd0;
        write_data  = 32'd0;
    endtask

    // One access on the default instance: request held for exactly one
    // cycle, then latency, data, error flag and pulse width are checked.
    task automatic run_access(input string tag, input logic rd, input logic wr,
                              input logic byt, input logic [31:0] addr,
                              input logic [31:0] wd, input logic [31:0] exp_rd,
                              input logic exp_err);
        int n;
        @(posedge clk); #1;
        mem_read    = rd;
        mem_write   = wr;
        byte_access = byt;
        address     = addr;
        write_data  = wd;
        @(posedge clk); #1;
        clear_req();
        n = 0;
        while (ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check_val({tag, "_lat"}, 32'(n), 32'd3);
        check_val({tag, "_rd"}, read_data, exp_rd);
        check_val({tag, "_err"}, {31'b0, addr_err}, {31'b0, exp_err});
        @(posedge clk); #1;
        check_val({tag, "_rdy_off"}, {31'b0, ready}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        clear_req();
        mem_read_z    = 1'b0;
        mem_write_z   = 1'b0;
        byte_access_z = 1'b0;
        address_z     = 32'd0;
        write_data_z  = 32'd0;

        repeat (3) @(posedge clk);
        #1;
        check_val("rst_ready", {31'b0, ready}, 32'd0);
        check_val("rst_err", {31'b0, addr_err}, 32'd0);
        check_val("rst_rd", read_data, 32'd0);
        check_val("rst_rd_z", read_data_z, 32'd0);
        rst_n = 1'b1;

        // Word write/read, read_data untouched by the write
        run_access("wr1028", 1'b0, 1'b1, 1'b0, 32'd1028, 32'h11223344, 32'h0, 1'b0);
        run_access("rd1028", 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, 32'h11223344, 1'b0);
        run_access("rd1031", 1'b1, 1'b0, 1'b0, 32'd1031, 32'h0, 32'h11223344, 1'b0);

        // Out of range; 1024 gets a known value so aliasing would show up
        run_access("wr1024", 1'b0, 1'b1, 1'b0, 32'd1024, 32'h01020304, 32'h11223344, 1'b0);
        run_access("rd1020", 1'b1, 1'b0, 1'b0, 32'd1020, 32'h0, 32'h0, 1'b1);
        run_access("wr1536", 1'b0, 1'b1, 1'b0, 32'd1536, 32'hDEADBEEF, 32'h0, 1'b1);
        run_access("rd1024", 1'b1, 1'b0, 1'b0, 32'd1024, 32'h0, 32'h01020304, 1'b0);

        // Reset in the second BUSY cycle of a write
        @(posedge clk); #1;
        mem_write  = 1'b1;
        address    = 32'd1028;
        write_data = 32'hAAAAAAAA;
        @(posedge clk); #1;
        clear_req();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_val("abort_ready", {31'b0, ready}, 32'd0);
        check_val("abort_err", {31'b0, addr_err}, 32'd0);
        check_val("abort_rd", read_data, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (ready === 1'b1) pulses++;
        end
        check_val("abort_no_ready", 32'(pulses), 32'd0);
        run_access("rd1028_post", 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, 32'h11223344, 1'b0);

`ifdef DMEM_BYTE_ACCESS_EN
        run_access("bwr1029", 1'b0, 1'b1, 1'b1, 32'd1029, 32'hFFFFFF5A, 32'h11223344, 1'b0);
        run_access("rd1028_b", 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, 32'h115A3344, 1'b0);
        run_access("brd1029", 1'b1, 1'b0, 1'b1, 32'd1029, 32'h0, 32'h0000005A, 1'b0);
        run_access("brd1536", 1'b1, 1'b0, 1'b1, 32'd1536, 32'h0, 32'h0, 1'b1);
`else
        // byte_access is ignored: these are plain word accesses at 1028
        run_access("brd1029", 1'b1, 1'b0, 1'b1, 32'd1029, 32'h0, 32'h11223344, 1'b0);
        run_access("bwr1029", 1'b0, 1'b1, 1'b1, 32'd1029, 32'hFFFFFF5A, 32'h11223344, 1'b0);
        run_access("rd1028_w", 1'b1, 1'b0, 1'b0, 32'd1028, 32'h0, 32'hFFFFFF5A, 1'b0);
`endif

        // Zero wait states, both requests held high: write every 2nd cycle
        @(posedge clk); #1;
        mem_read_z   = 1'b1;
        mem_write_z  = 1'b1;
        address_z    = 32'd1032;
        write_data_z = 32'h0000CAFE;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check_val($sformatf("z_ready%0d", i), {31'b0, ready_z},
                      (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        mem_read_z   = 1'b0;
        mem_write_z  = 1'b0;
        address_z    = 32'd0;
        write_data_z = 32'd0;
        check_val("z_rd_after_wr", read_data_z, 32'd0);
        @(posedge clk); #1;
        mem_read_z = 1'b1;
        address_z  = 32'd1032;
        @(posedge clk); #1;
        mem_read_z = 1'b0;
        address_z  = 32'd0;
        check_val("z_rd_ready", {31'b0, ready_z}, 32'd1);
        check_val("z_rd1032", read_data_z, 32'h0000CAFE);
        check_val("z_rd_err", {31'b0, addr_err_z}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
